// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM-side signals of the memory port arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_done;
    logic [DATA_W-1:0] rdata;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        output if_gnt, if_rvalid, d_gnt, d_done, rdata,
               ram_en, ram_we, ram_addr, ram_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        input  if_gnt, if_rvalid, d_gnt, d_done, rdata,
               ram_en, ram_we, ram_addr, ram_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port RAM between the
// instruction-fetch and data requesters; one access in flight at a time.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RAM_LAT = 1
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

    state_t           state;
    owner_t           owner;
    owner_t           last_owner;
    logic             we_q;
    logic [CNT_W-1:0] cnt;
    logic             pick_data_c;

    // Arbitration: a lone requester wins; on contention the side that did not go last wins.
    always_comb begin
        pick_data_c = 1'b0;
        if (bus.d_req && !bus.if_req) begin
            pick_data_c = 1'b1;
        end else if (bus.d_req && bus.if_req) begin
            pick_data_c = (last_owner == OWN_FETCH);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= OWN_FETCH;
            last_owner    <= OWN_DATA;
            we_q          <= 1'b0;
            cnt           <= CNT_W'(0);
            bus.if_gnt    <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.d_gnt     <= 1'b0;
            bus.d_done    <= 1'b0;
            bus.ram_en    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= ADDR_W'(0);
            bus.ram_wdata <= DATA_W'(0);
            bus.rdata     <= DATA_W'(0);
            bus.busy      <= 1'b0;
        end else begin
            // Strobes and pulses last a single cycle unless re-asserted below.
            bus.if_gnt    <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.d_gnt     <= 1'b0;
            bus.d_done    <= 1'b0;
            bus.ram_en    <= 1'b0;
            bus.ram_we    <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        state      <= ACCESS;
                        bus.busy   <= 1'b1;
                        bus.ram_en <= 1'b1;
                        cnt        <= CNT_W'(RAM_LAT);
                        if (pick_data_c) begin
                            owner         <= OWN_DATA;
                            last_owner    <= OWN_DATA;
                            we_q          <= bus.d_we;
                            bus.ram_we    <= bus.d_we;
                            bus.ram_addr  <= bus.d_addr;
                            bus.ram_wdata <= bus.d_wdata;
                            bus.d_gnt     <= 1'b1;
                        end else begin
                            owner        <= OWN_FETCH;
                            last_owner   <= OWN_FETCH;
                            we_q         <= 1'b0;
                            bus.ram_addr <= bus.if_addr;
                            bus.if_gnt   <= 1'b1;
                        end
                    end
                end

                ACCESS: begin
                    if (we_q) begin
                        state <= DONE;
                        if (owner == OWN_DATA) bus.d_done    <= 1'b1;
                        else                   bus.if_rvalid <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end

                // Reads spend RAM_LAT cycles here; the last one carries valid ram_rdata.
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state     <= DONE;
                        bus.rdata <= bus.ram_rdata;
                        if (owner == OWN_DATA) bus.d_done    <= 1'b1;
                        else                   bus.if_rvalid <= 1'b1;
                    end
                end

                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-timing reference model, on two instances (RAM_LAT = 1 and 3).
module tb_mem_port_arbiter;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int          MEM_N  = 16;

    logic              clk;
    logic              reset;
    logic              mem_init;
    logic              sel;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;

    int n_cmp;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_word(input int i);
        return (i == 5) ? 32'hDEADBEEF : (32'hC0DE0000 + 32'(i));
    endfunction

    // ctl bit order: {busy, if_gnt, d_gnt, ram_en, ram_we, if_rvalid, d_done}
    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int unsigned LAT = (k == 0) ? 1 : 3;

        mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

        assign bus.if_req  = if_req;
        assign bus.if_addr = if_addr;
        assign bus.d_req   = d_req;
        assign bus.d_we    = d_we;
        assign bus.d_addr  = d_addr;
        assign bus.d_wdata = d_wdata;

        mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(LAT)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        // RAM model: read data is driven only in cycle A+LAT, random junk otherwise.
        logic [DATA_W-1:0] mem [MEM_N];
        logic [LAT-1:0]    pv;
        logic [3:0]        pa [LAT];
        logic [DATA_W-1:0] junk;

        always @(posedge clk) begin
            junk <= $urandom;
            if (mem_init) begin
                for (int i = 0; i < MEM_N; i++) mem[i] <= init_word(i);
            end else if (bus.ram_en && bus.ram_we) begin
                mem[bus.ram_addr[3:0]] <= bus.ram_wdata;
            end
            pv[0] <= bus.ram_en && !bus.ram_we;
            pa[0] <= bus.ram_addr[3:0];
            for (int i = 1; i < int'(LAT); i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end

        assign bus.ram_rdata = pv[LAT-1] ? mem[pa[LAT-1]] : junk;

        wire [6:0] ctl = {bus.busy, bus.if_gnt, bus.d_gnt, bus.ram_en,
                          bus.ram_we, bus.if_rvalid, bus.d_done};
    end

    wire [6:0]        o_ctl   = sel ? g_dut[1].ctl : g_dut[0].ctl;
    wire [ADDR_W-1:0] o_addr  = sel ? g_dut[1].bus.ram_addr  : g_dut[0].bus.ram_addr;
    wire [DATA_W-1:0] o_wdata = sel ? g_dut[1].bus.ram_wdata : g_dut[0].bus.ram_wdata;
    wire [DATA_W-1:0] o_rdata = sel ? g_dut[1].bus.rdata     : g_dut[0].bus.rdata;

    task automatic do_reset();
        reset = 1'b1; mem_init = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0; mem_init = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            n_cmp++;
            if (o_ctl !== 7'b0) begin
                n_err++; $display("FAIL reset_ctl dut=%0d got=%b exp=%b", s, o_ctl, 7'b0);
            end
            n_cmp++;
            if ({o_addr, o_wdata, o_rdata} !== '0) begin
                n_err++; $display("FAIL reset_regs dut=%0d addr=%h wdata=%h rdata=%h exp=0", s, o_addr, o_wdata, o_rdata);
            end
        end
    endtask

    task automatic test_fetch();
        sel = 1'b0;
        @(negedge clk); if_req = 1'b1; if_addr = 16'h0005;
        @(negedge clk);
        n_cmp++;
        if (o_ctl !== 7'b1101000 || o_addr !== 16'h0005) begin
            n_err++; $display("FAIL fetch_A got=%b/%h exp=1101000/0005", o_ctl, o_addr);
        end
        if_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_ctl !== 7'b1000000) begin
            n_err++; $display("FAIL fetch_A1 got=%b exp=1000000", o_ctl);
        end
        @(negedge clk);
        n_cmp++;
        if (o_ctl !== 7'b1000010 || o_rdata !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL fetch_A2 got=%b/%h exp=1000010/deadbeef", o_ctl, o_rdata);
        end
        @(negedge clk);
        n_cmp++;
        if (o_ctl !== 7'b0) begin
            n_err++; $display("FAIL fetch_A3 got=%b exp=0000000", o_ctl);
        end
    endtask

    task automatic test_write();
        sel = 1'b0;
        @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 32'h12345678;
        @(negedge clk);
        n_cmp++;
        if (o_ctl !== 7'b1011100 || o_addr !== 16'h0010 || o_wdata !== 32'h12345678) begin
            n_err++; $display("FAIL write_A got=%b/%h/%h exp=1011100/0010/12345678", o_ctl, o_addr, o_wdata);
        end
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_ctl !== 7'b1000001 || o_rdata !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL write_A1 got=%b/%h exp=1000001/deadbeef", o_ctl, o_rdata);
        end
        @(negedge clk);
        n_cmp++;
        if (o_ctl !== 7'b0) begin
            n_err++; $display("FAIL write_A2 got=%b exp=0000000", o_ctl);
        end
    endtask

    task automatic test_contention();
        logic e_if, e_d;
        sel = 1'b0;
        do_reset();
        if_req = 1'b1; if_addr = 16'h0001; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0002;
        // Reads at RAM_LAT=1 are accepted every 4 cycles, alternating fetch/data.
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            e_if = (t % 4 == 1) && ((t / 4) % 2 == 0);
            e_d  = (t % 4 == 1) && ((t / 4) % 2 == 1);
            n_cmp++;
            if (o_ctl[5:4] !== {e_if, e_d}) begin
                n_err++; $display("FAIL contention t=%0d gnt(if,d) got=%b exp=%b", t, o_ctl[5:4], {e_if, e_d});
            end
        end
        if_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_lat3();
        sel = 1'b1;
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
        @(negedge clk);
        n_cmp++;
        if (o_ctl !== 7'b1011000 || o_addr !== 16'h0020) begin
            n_err++; $display("FAIL lat3_A got=%b/%h exp=1011000/0020", o_ctl, o_addr);
        end
        d_req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (o_ctl !== 7'b1000000 || o_rdata !== 32'h0) begin
                n_err++; $display("FAIL lat3_wait k=%0d got=%b/%h exp=1000000/0", k, o_ctl, o_rdata);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (o_ctl !== 7'b1000001 || o_rdata !== init_word(0)) begin
            n_err++; $display("FAIL lat3_done got=%b/%h exp=1000001/%h", o_ctl, o_rdata, init_word(0));
        end
        @(negedge clk);
        n_cmp++;
        if (o_ctl !== 7'b0) begin
            n_err++; $display("FAIL lat3_idle got=%b exp=0000000", o_ctl);
        end
    endtask

    task automatic test_reset_mid();
        sel = 1'b1;
        @(negedge clk); if_req = 1'b1; if_addr = 16'h0005;
        @(negedge clk);
        n_cmp++;
        if (o_ctl !== 7'b1101000) begin
            n_err++; $display("FAIL rstmid_A got=%b exp=1101000", o_ctl);
        end
        if_req = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (o_ctl !== 7'b0 || o_rdata !== 32'h0) begin
            n_err++; $display("FAIL rstmid_after got=%b/%h exp=0000000/0", o_ctl, o_rdata);
        end
        reset = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0007;
        @(negedge clk);
        n_cmp++;
        if (o_ctl !== 7'b1011000) begin
            n_err++; $display("FAIL rstmid_dgnt got=%b exp=1011000", o_ctl);
        end
        d_req = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (o_ctl !== ((k == 5) ? 7'b0 : (k == 4) ? 7'b1000001 : 7'b1000000)) begin
                n_err++; $display("FAIL rstmid_tail k=%0d got=%b", k, o_ctl);
            end
        end
    endtask

    task automatic test_late_req();
        sel = 1'b0;
        do_reset();
        if_req = 1'b1; if_addr = 16'h0033;
        @(negedge clk);
        n_cmp++;
        if (o_ctl !== 7'b1101000) begin
            n_err++; $display("FAIL late_A got=%b exp=1101000", o_ctl);
        end
        if_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_ctl !== 7'b1000000) begin
            n_err++; $display("FAIL late_A1 got=%b exp=1000000", o_ctl);
        end
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0044; d_wdata = 32'hA5A55A5A;
        @(negedge clk);
        n_cmp++;
        if (o_ctl !== 7'b1000010) begin
            n_err++; $display("FAIL late_A2 got=%b exp=1000010", o_ctl);
        end
        @(negedge clk);
        n_cmp++;
        if (o_ctl !== 7'b0) begin
            n_err++; $display("FAIL late_A3 got=%b exp=0000000", o_ctl);
        end
        @(negedge clk);
        n_cmp++;
        if (o_ctl !== 7'b1011100 || o_wdata !== 32'hA5A55A5A || o_addr !== 16'h0044) begin
            n_err++; $display("FAIL late_A4 got=%b/%h/%h exp=1011100/0044/a5a55a5a", o_ctl, o_addr, o_wdata);
        end
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_ctl !== 7'b1000001) begin
            n_err++; $display("FAIL late_A5 got=%b exp=1000001", o_ctl);
        end
    endtask

    // Model: each accepted access occupies cycles A..A+1 (write) or A..A+lat+1 (read);
    // requests are sampled only in the cycle after that window closes.
    task automatic test_random(input logic s, input int lat);
        logic [DATA_W-1:0] ref_mem [MEM_N];
        logic              in_flight, acc_data, acc_we, last_data;
        int                acc_a, acc_done;
        logic [ADDR_W-1:0] acc_addr, exp_addr;
        logic [DATA_W-1:0] acc_wdata, exp_rdata;
        logic [6:0]        e_ctl;
        logic              at_a, at_done;

        sel = s;
        do_reset();
        for (int i = 0; i < MEM_N; i++) ref_mem[i] = init_word(i);
        in_flight = 1'b0; last_data = 1'b1; acc_data = 1'b0; acc_we = 1'b0;
        acc_a = 0; acc_done = 0; acc_addr = '0; acc_wdata = '0;
        exp_addr = '0; exp_rdata = '0;

        for (int n = 1; n <= 600; n++) begin
            @(negedge clk);
            if (in_flight && n > acc_done) in_flight = 1'b0;
            at_a    = in_flight && (n == acc_a);
            at_done = in_flight && (n == acc_done);
            if (at_a) begin
                exp_addr = acc_addr;
                if (acc_we) ref_mem[acc_addr[3:0]] = acc_wdata;
                if (acc_data) d_req = 1'b0; else if_req = 1'b0;
            end
            if (at_done && !acc_we) exp_rdata = ref_mem[acc_addr[3:0]];
            e_ctl = {in_flight, at_a && !acc_data, at_a && acc_data, at_a,
                     at_a && acc_we, at_done && !acc_data, at_done && acc_data};

            n_cmp++;
            if (o_ctl !== e_ctl) begin
                n_err++; $display("FAIL rnd_ctl lat=%0d cyc=%0d got=%b exp=%b", lat, n, o_ctl, e_ctl);
            end
            n_cmp++;
            if (o_addr !== exp_addr) begin
                n_err++; $display("FAIL rnd_addr lat=%0d cyc=%0d got=%h exp=%h", lat, n, o_addr, exp_addr);
            end
            n_cmp++;
            if (o_rdata !== exp_rdata) begin
                n_err++; $display("FAIL rnd_rdata lat=%0d cyc=%0d got=%h exp=%h", lat, n, o_rdata, exp_rdata);
            end
            if (at_a && acc_we) begin
                n_cmp++;
                if (o_wdata !== acc_wdata) begin
                    n_err++; $display("FAIL rnd_wdata lat=%0d cyc=%0d got=%h exp=%h", lat, n, o_wdata, acc_wdata);
                end
            end

            if (!if_req && $urandom_range(3) == 0) begin
                if_req = 1'b1; if_addr = ADDR_W'($urandom);
            end
            if (!d_req && $urandom_range(3) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(1));
                d_addr = ADDR_W'($urandom); d_wdata = DATA_W'($urandom);
            end

            if (!in_flight && (if_req || d_req)) begin
                acc_data  = d_req && (!if_req || !last_data);
                last_data = acc_data;
                acc_we    = acc_data && d_we;
                acc_addr  = acc_data ? d_addr : if_addr;
                acc_wdata = d_wdata;
                acc_a     = n + 1;
                acc_done  = acc_a + (acc_we ? 1 : lat + 1);
                in_flight = 1'b1;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; sel = 1'b0;
        test_reset();
        test_fetch();
        test_write();
        test_contention();
        test_lat3();
        test_reset_mid();
        test_late_req();
        test_random(1'b0, 1);
        test_random(1'b1, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the end of the test sequence");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port instruction/data RAM between two requesters.
  - Instruction-fetch side (state machine / PC path).
  - Data side (load/store from the MAB/RBT path).
- Sequences each access through a fixed-latency RAM handshake.
- Returns read data with a one-cycle valid pulse to the owning requester.
- Alternates ownership when both sides request at once (round-robin), so neither side starves.

Parameters:
- ADDR_W, 16, width of RAM address (matches PC width).
- DATA_W, 32, width of RAM data word (matches instruction width).
- RAM_LAT, 1, cycles from address cycle to ram_rdata valid. Legal range 1..15.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request, level, held until if_gnt.
- if_addr  in  ADDR_W  fetch address, valid while if_req=1.
- if_gnt  out  1  one-cycle pulse: fetch request accepted.
- if_rvalid  out  1  one-cycle pulse: rdata holds fetched word.
- d_req  in  1  data request, level, held until d_gnt.
- d_we  in  1  1=write, 0=read, valid with d_req.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_done  out  1  one-cycle pulse: data access complete (read: rdata valid).
- rdata  out  DATA_W  last captured read word, shared by both sides.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable, qualified by ram_en.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- States: IDLE, ACCESS, WAIT, DONE. All outputs are registered or decoded from state only; there are no combinational paths from request inputs to outputs.
- Reset (sync, any state):
  - State goes to IDLE.
  - if_gnt, if_rvalid, d_gnt, d_done, ram_en, ram_we = 0.
  - ram_addr, ram_wdata, rdata = 0.
  - Wait counter = 0.
  - last_owner = DATA, so fetch wins the first contention.
  - An access in flight is abandoned and produces no completion pulse.
- IDLE: requests are sampled only in this state.
  - Only one of if_req/d_req high: that side wins.
  - Both high: the side that is not last_owner wins.
  - At the clock edge:
    - Latch the winner's address, we (fetch forces we=0) and wdata into ram_* registers.
    - Record owner and update last_owner.
    - Load counter = RAM_LAT.
    - Go to ACCESS.
  - Neither high: stay in IDLE.
- ACCESS (exactly one cycle, cycle A):
  - ram_en=1; ram_we=latched we.
  - Winner's gnt=1 this cycle only.
  - Write: next state DONE.
  - Read with RAM_LAT=1: next state DONE; capture ram_rdata into rdata at the end of cycle A+1 (see WAIT rule). Implementation: RAM_LAT=1 passes through WAIT for one cycle.
  - Read, general case: next state WAIT.
- WAIT:
  - ram_en=0; counter decrements each cycle.
  - In cycle A+RAM_LAT, ram_rdata is valid: capture it into rdata and go to DONE.
- DONE (one cycle, A+RAM_LAT+1 for reads, A+1 for writes):
  - Owner's completion pulse = 1: if_rvalid for fetch, d_done for data.
  - Next state IDLE.
  - rdata is unchanged on writes and holds until the next read capture.
- ram_addr/ram_wdata hold their latched values outside ACCESS. ram_we=0 outside ACCESS.
- Requester rule: drop req by the cycle after gnt, or it is re-arbitrated as a new access at the next IDLE. Requests raised while busy wait; they are not lost.
- Minimum spacing between accepts: read 3+RAM_LAT cycles, write 3 cycles.
- Fetch address is never written: if_* side has no write path.

Test Plan:
- Reset then single fetch: if_req=1, if_addr=0x0005, RAM_LAT=1, ram_rdata=0xDEADBEEF in cycle A+1 -> if_gnt in cycle A, ram_en=1/ram_we=0/ram_addr=0x0005 in A, if_rvalid and rdata=0xDEADBEEF in A+2, busy falls in A+3.
- Data write: d_req=1, d_we=1, d_addr=0x0010, d_wdata=0x12345678 -> d_gnt and ram_en=ram_we=1 with ram_wdata=0x12345678 in A; d_done in A+1; rdata unchanged.
- Contention: if_req and d_req held high together from reset -> grant order fetch, data, fetch, data; each gnt pulse exactly one cycle.
- RAM_LAT=3 read: d_req read at 0x0020 -> ram_en only in A; rdata captured from ram_rdata in A+3; d_done in A+4; no if_rvalid.
- Reset mid-operation: assert reset in WAIT of a fetch -> next cycle IDLE, busy=0, rdata=0, no if_rvalid ever issued for that access; a fresh d_req then wins, since last_owner=DATA resets priority to fetch only on contention.
- Late request: d_req asserted in WAIT of a fetch -> no d_gnt until the fetch's DONE completes; d_gnt in the first ACCESS after IDLE.
